// File: rtl/iscbsqrt_ctrl_if.sv
// Job/stream bundle between the square-root job controller and its requester/unit side.
// valid/ready: req is taken only while busy=0; done pulses once per finished job, result holds until the next done.
interface iscbsqrt_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             req;
   logic [WIDTH-1:0] operand;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             unit_rst_n;
   logic             unit_in;
   logic             unit_out;
   logic [2:0]       state_dbg;

   modport slave (
      input  req, operand, abort, unit_out,
      output busy, done, result, unit_rst_n, unit_in, state_dbg
   );

   modport master (
      output req, operand, abort, unit_out,
      input  busy, done, result, unit_rst_n, unit_in, state_dbg
   );
endinterface

// File: rtl/iscbsqrt_ctrl.sv
// Job controller: streams an LFSR-compared operand into the stochastic unit,
// skips a warm-up window, then counts unit ones over 2^WIDTH cycles.
module iscbsqrt_ctrl #(
   parameter int WIDTH  = 8,
   parameter int WARMUP = 16,
   parameter int SEED   = 1
) (
   input logic            clk,
   input logic            rst_n,
   iscbsqrt_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_WARM  = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam int CW = 12;
   localparam logic [CW-1:0] RUN_LAST  = CW'((1 << WIDTH) - 1);
   localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
   localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);
   localparam int TAPS_I = (WIDTH == 4) ? 'h00C :
                           (WIDTH == 5) ? 'h014 :
                           (WIDTH == 6) ? 'h030 :
                           (WIDTH == 7) ? 'h060 :
                           (WIDTH == 8) ? 'h0B8 :
                           (WIDTH == 9) ? 'h110 : 'h240;
   localparam logic [WIDTH-1:0] TAPS = WIDTH'(TAPS_I);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] operand_q;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_next;
   logic [CW-1:0]    cyc_q;
   logic [WIDTH:0]   ones_q;
   logic [WIDTH:0]   ones_next;
   logic [WIDTH-1:0] result_q;
   logic             unit_rst_q;
   logic             streaming;

   assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
   assign ones_next = ones_q + {{WIDTH{1'b0}}, bus.unit_out};
   assign streaming = (state_q == S_WARM) || (state_q == S_RUN);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.req) state_d = S_RESET;
         S_RESET: state_d = (WARMUP == 0) ? S_RUN : S_WARM;
         S_WARM:  if (cyc_q == WARM_LAST) state_d = S_RUN;
         S_RUN:   if (cyc_q == RUN_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Cancel wins over every other transition, including RUN -> DONE.
      if (bus.abort && (state_q == S_RESET || streaming)) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         operand_q  <= '0;
         lfsr_q     <= SEED_V;
         cyc_q      <= '0;
         ones_q     <= '0;
         result_q   <= '0;
         unit_rst_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         unit_rst_q <= (state_d != S_RESET);
         if (state_q == S_IDLE && state_d == S_RESET) operand_q <= bus.operand;
         case (state_q)
            S_RESET: begin
               lfsr_q <= SEED_V;
               cyc_q  <= '0;
               ones_q <= '0;
            end
            S_WARM: begin
               lfsr_q <= lfsr_next;
               cyc_q  <= (cyc_q == WARM_LAST) ? '0 : cyc_q + CW'(1);
            end
            S_RUN: begin
               lfsr_q <= lfsr_next;
               cyc_q  <= cyc_q + CW'(1);
               ones_q <= ones_next;
            end
            default: ;
         endcase
         // The final RUN cycle's unit_out is folded in here so result is valid with done.
         if (state_q == S_RUN && state_d == S_DONE)
            result_q <= ones_next[WIDTH] ? '1 : ones_next[WIDTH-1:0];
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.result     = result_q;
   assign bus.unit_rst_n = unit_rst_q;
   assign bus.unit_in    = streaming && (operand_q > lfsr_q);
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_iscbsqrt_ctrl.sv
// Directed + randomized bench for iscbsqrt_ctrl (WIDTH=8, WARMUP=16, SEED=1) with stub units.
module tb_iscbsqrt_ctrl;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   mode;
   logic drv_bit;
   logic [7:0] seq [0:299];
   logic [7:0] res;

   iscbsqrt_ctrl_if #(.WIDTH(8)) bus ();

   iscbsqrt_ctrl #(.WIDTH(8), .WARMUP(16), .SEED(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Stub unit: 0 = constant one, 1 = constant zero, 2 = echo of unit_in, 3 = random bits.
   assign bus.unit_out = (mode == 2) ? bus.unit_in :
                         (mode == 0) ? 1'b1 :
                         (mode == 1) ? 1'b0 : drv_bit;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts in cycle 0 (just after a negedge); req is accepted at the next posedge.
   task automatic run_job(input logic [7:0] op, input int mode_i, input int abort_at,
                          input int rst_at, input int pulse_at, input logic [7:0] prior,
                          output logic [7:0] res_out);
      int   ones;
      bit   uo;
      bit   exp_in;
      logic [7:0] exp_res;
      mode = mode_i;
      ones = 0;
      exp_res = prior;
      bus.req = 1'b1;
      bus.operand = op;
      for (int n = 1; n <= 276; n++) begin
         @(negedge clk);
         bus.req     = (n == pulse_at);
         bus.operand = 8'($urandom);
         bus.abort   = (n == abort_at);
         drv_bit     = 1'($urandom_range(0, 1));
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_result", bus.result, 0);
            check("rst_unit_rst_n", bus.unit_rst_n, 0);
            check("rst_unit_in", bus.unit_in, 0);
            @(negedge clk);
            rst_n = 1'b1;
            res_out = 8'h00;
            return;
         end
         if (abort_at > 0 && n > abort_at) begin
            check("abort_busy", bus.busy, 0);
            check("abort_done", bus.done, 0);
            check("abort_result", bus.result, prior);
            check("abort_unit_in", bus.unit_in, 0);
         end else begin
            check("busy", bus.busy, (n <= 274) ? 1 : 0);
            check("done", bus.done, (n == 274) ? 1 : 0);
            check("unit_rst_n", bus.unit_rst_n, (n == 1) ? 0 : 1);
            exp_in = (n >= 2 && n <= 273) ? (op > seq[n-2]) : 1'b0;
            if (n >= 2) check("unit_in", bus.unit_in, exp_in);
            if (n >= 18 && n <= 273) begin
               uo = (mode_i == 0) ? 1'b1 : (mode_i == 1) ? 1'b0 :
                    (mode_i == 2) ? exp_in : drv_bit;
               ones += uo;
            end
            if (n == 274) exp_res = (ones > 255) ? 8'hFF : 8'(ones);
            if (n >= 274) check("result", bus.result, exp_res);
         end
      end
      bus.req   = 1'b0;
      bus.abort = 1'b0;
      res_out = exp_res;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      mode = 1;
      drv_bit = 1'b0;
      rst_n = 1'b0;
      bus.req = 1'b0;
      bus.operand = '0;
      bus.abort = 1'b0;
      // LFSR reference: shift left, new bit 0 = XOR of taps 8,6,5,4.
      seq[0] = 8'h01;
      for (int i = 0; i < 299; i++)
         seq[i+1] = {seq[i][6:0], seq[i][7] ^ seq[i][5] ^ seq[i][4] ^ seq[i][3]};

      repeat (2) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_result", bus.result, 0);
      check("reset_unit_rst_n", bus.unit_rst_n, 0);
      check("reset_unit_in", bus.unit_in, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_unit_rst_n", bus.unit_rst_n, 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("idle_abort_busy", bus.busy, 0);

      run_job(8'h40, 0, 0, 0, 50, 8'h00, res);
      check("sat_result", res, 8'hFF);
      run_job(8'hC3, 1, 100, 0, 0, res, res);
      check("abort_kept", res, 8'hFF);
      run_job(8'h40, 1, 0, 0, 0, res, res);
      check("zero_result", res, 8'h00);
      run_job(8'h00, 2, 0, 0, 0, res, res);
      check("echo_zero", res, 8'h00);
      run_job(8'h80, 2, 0, 0, 0, res, res);
      for (int k = 0; k < 4; k++) run_job(8'($urandom), 2, 0, 0, 0, res, res);
      for (int k = 0; k < 2; k++) run_job(8'($urandom), 3, 0, 0, 0, res, res);

      // req held high: back-to-back jobs with one IDLE cycle in between.
      mode = 0;
      bus.req = 1'b1;
      bus.operand = 8'h55;
      for (int n = 1; n <= 600; n++) begin
         @(negedge clk);
         check("b2b_done", bus.done, (n == 274 || n == 549) ? 1 : 0);
         check("b2b_busy", bus.busy, (n == 275 || n == 550) ? 0 : 1);
      end
      bus.req = 1'b0;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("b2b_abort_busy", bus.busy, 0);
      check("b2b_result", bus.result, 8'hFF);

      run_job(8'h99, 2, 0, 10, 0, 8'hFF, res);
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_unit_rst_n", bus.unit_rst_n, 1);
      run_job(8'hE1, 3, 0, 0, 0, res, res);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
